// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the core's single data-memory port between the CPU
//               datapath and a host/debug port. The CPU owns the port by
//               default. A host request gets one slot when the CPU is idle,
//               or after a bounded wait. Optional stall counter is enabled
//               with `define DMEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int c_WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    CPU_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                r_host_ack;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                w_cpu_busy;
  logic                w_req_eff;
  logic                w_host_own;

  assign w_cpu_busy = cpu_rd | cpu_wr;
  // Masking the request during its ack cycle prevents a held request from
  // being serviced twice.
  assign w_req_eff  = host_req & ~r_host_ack;
  assign w_host_own = (r_state == HOST_OWN);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      CPU_OWN: begin
        if (w_req_eff && (!w_cpu_busy || (r_wait_cnt == c_WAIT_LAST))) begin
          w_state_nxt = HOST_OWN;
          w_wait_nxt  = '0;
        end else if (w_req_eff) begin
          if (r_wait_cnt != c_WAIT_LAST) begin
            w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
          end
        end else begin
          w_wait_nxt = '0;
        end
      end
      HOST_OWN: begin
        w_state_nxt = CPU_OWN;
        w_wait_nxt  = '0;
      end
      default: begin
        w_state_nxt = CPU_OWN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CPU_OWN;
      r_wait_cnt   <= '0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_host_ack <= w_host_own;
      if (w_host_own && !host_we) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  // Strobes are gated by rst_n so nothing reaches memory while in reset.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (w_host_own) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
    if (rst_n) begin
      if (w_host_own) begin
        mem_rd = ~host_we;
        mem_wr = host_we;
      end else begin
        mem_rd = cpu_rd;
        mem_wr = cpu_wr;
      end
    end
  end

  assign cpu_stall  = w_host_own & w_cpu_busy;
  assign cpu_rdata  = mem_rdata;
  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (cpu_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomized self-checking bench for dmem_arbiter against a
//               cycle-level behavioural model with its own memory image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } hreq_t;

  logic       clk = 1'b0;
  logic       rst_n, cpu_rd, cpu_wr, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_ack;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_count;
`endif

  logic [7:0] dmem [256];
  assign mem_rdata = dmem[mem_addr];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long the host has waited.
  bit          m_host, m_ack;
  int          m_wait;
  logic [7:0]  m_rdata;
  logic [15:0] m_scnt;
  logic [7:0]  m_mem [256];

  // Stimulus state.
  int         cpu_mode, h_age, rst_hold;
  logic [7:0] cpu_fix;
  bit         host_rand, h_busy, arm_rst, starve;
  hreq_t      hq[$];
  bit         pw_en;
  logic [7:0] pw_addr, pw_data;

  task automatic edge_update();
    bit busy, req_eff;
    busy    = cpu_rd | cpu_wr;
    req_eff = host_req && !m_ack;
    if (!rst_n) begin
      m_host = 0; m_wait = 0; m_ack = 0; m_rdata = 8'h00; m_scnt = 16'h0000;
    end else begin
      if (h_busy) h_age++;
      if (m_host && busy && m_scnt != 16'hFFFF) m_scnt++;
      if (m_host) begin
        if (host_we) m_mem[host_addr] = host_wdata;
        else         m_rdata = m_mem[host_addr];
        m_ack = 1; m_host = 0; m_wait = 0;
      end else begin
        if (cpu_wr) m_mem[cpu_addr] = cpu_wdata;
        m_ack = 0;
        if (req_eff && (!busy || m_wait == MAX_WAIT - 1)) begin
          m_host = 1; m_wait = 0;
        end else if (req_eff) begin
          if (m_wait < MAX_WAIT - 1) m_wait++;
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  task automatic apply_inputs();
    hreq_t r;
    int    op;
    if (arm_rst && m_host && rst_n) begin
      rst_hold = 2; arm_rst = 0;
    end
    if (rst_hold > 0) begin
      rst_n = 1'b0; rst_hold--;
    end else begin
      rst_n = 1'b1;
    end
    case (cpu_mode)
      0: begin cpu_rd = 0; cpu_wr = 0; end
      1: begin cpu_rd = 1; cpu_wr = 0; cpu_addr = cpu_fix; end
      default: begin
        op        = $urandom_range(0, 3);
        cpu_rd    = (op == 1) || (op == 3);
        cpu_wr    = (op == 2);
        cpu_addr  = 8'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
    endcase
    if (!rst_n) begin
      h_busy     = 0;
      host_req   = 1'($urandom);
      host_we    = 1'($urandom);
      host_addr  = 8'($urandom);
      host_wdata = 8'($urandom);
    end else if (m_ack) begin
      // Sometimes keep the request high through the ack cycle.
      h_busy   = 0;
      host_req = host_req & 1'($urandom);
    end else if (!h_busy) begin
      if (hq.size() > 0) begin
        r = hq.pop_front();
        h_busy = 1; h_age = 0; host_req = 1;
        host_we = r.we; host_addr = r.addr; host_wdata = r.data;
      end else if (host_rand && $urandom_range(0, 2) == 0) begin
        h_busy = 1; h_age = 0; host_req = 1;
        host_we = 1'($urandom); host_addr = 8'($urandom_range(0, 31));
        host_wdata = 8'($urandom);
      end else begin
        host_req = 0;
      end
    end
  endtask

  task automatic comb_check();
    logic       e_rd, e_wr, e_st;
    logic [7:0] e_a, e_d;
    e_rd = 0; e_wr = 0; e_st = 0; e_a = cpu_addr; e_d = cpu_wdata;
    if (rst_n && m_host) begin
      e_rd = !host_we; e_wr = host_we; e_a = host_addr; e_d = host_wdata;
      e_st = cpu_rd | cpu_wr;
    end else if (rst_n) begin
      e_rd = cpu_rd; e_wr = cpu_wr;
    end
    chk("mem_rd", mem_rd, e_rd);
    chk("mem_wr", mem_wr, e_wr);
    if (e_rd || e_wr) chk("mem_addr", mem_addr, e_a);
    if (e_wr) chk("mem_wdata", mem_wdata, e_d);
    chk("cpu_stall", cpu_stall, e_st);
    if (rst_n && !m_host && cpu_rd) chk("cpu_rdata", cpu_rdata, m_mem[cpu_addr]);
  endtask

  task automatic cycle();
    pw_en = mem_wr; pw_addr = mem_addr; pw_data = mem_wdata;
    @(posedge clk);
    if (pw_en) dmem[pw_addr] = pw_data;
    edge_update();
    #1;
    chk("host_ack", host_ack, m_ack);
    chk("host_rdata", host_rdata, m_rdata);
`ifdef DMEM_ARB_PERF_EN
    chk("stall_count", stall_count, m_scnt);
`endif
    if (host_ack && h_busy) begin
      if (starve) chk("latency", h_age, MAX_WAIT + 1);
      else        chk("latency_max", h_age <= MAX_WAIT + 1, 1);
    end
    apply_inputs();
    #1;
    comb_check();
  endtask

  initial begin
    logic [7:0]  v, old30;
    logic [15:0] s0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom); dmem[i] = v; m_mem[i] = v;
    end
    dmem[8'h22] = 8'h3C; m_mem[8'h22] = 8'h3C;
    m_host = 0; m_ack = 0; m_wait = 0; m_rdata = 8'h00; m_scnt = 16'h0000;
    h_busy = 0; h_age = 0; arm_rst = 0; starve = 0; host_rand = 0;
    cpu_mode = 2; cpu_fix = 8'h00; rst_hold = 2;
    cpu_addr = 8'h00; cpu_wdata = 8'h00;
    apply_inputs();
    #1;
    comb_check();
    repeat (2) cycle();

    // Host write with idle CPU, then CPU reads it back.
    cpu_mode = 0;
    hq.push_back('{1'b1, 8'h10, 8'hA5});
    repeat (4) cycle();
    cpu_mode = 1; cpu_fix = 8'h10;
    cycle();
    chk("cpu_rd_0x10", cpu_rdata, 8'hA5);

    // Host read.
    cpu_mode = 0;
    hq.push_back('{1'b0, 8'h22, 8'h00});
    repeat (4) cycle();
    chk("host_rd_0x22", host_rdata, 8'h3C);

    // Starvation: CPU reads every cycle, three host accesses.
    s0 = m_scnt;
    cpu_mode = 1; cpu_fix = 8'h2A; starve = 1;
    repeat (3) hq.push_back('{1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom)});
    repeat (20) cycle();
    starve = 0;
`ifdef DMEM_ARB_PERF_EN
    chk("stall_busy3", stall_count, s0 + 16'd3);
`endif

    // Host accesses with idle CPU add no stalls.
    cpu_mode = 0;
    repeat (2) hq.push_back('{1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom)});
    repeat (10) cycle();
`ifdef DMEM_ARB_PERF_EN
    chk("stall_idle", stall_count, s0 + 16'd3);
`endif

    // Reset while the host owns the port with a pending write.
    old30 = dmem[8'h30];
    hq.push_back('{1'b1, 8'h30, 8'h55});
    arm_rst = 1;
    repeat (8) cycle();
    chk("rst_mid_mem", dmem[8'h30], old30);

    // Random traffic.
    cpu_mode = 2; host_rand = 1;
    repeat (3000) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
